// File: rtl/ma_sched_pkg.sv
// ma_sched_pkg -- shared types and sizing helpers for the tile scheduler.
//   sched_state_e    : scheduler FSM states
//   GUARD_CYCLES     : idle cycles between a tile's last result row and the next fetch
//   timeout_cycles() : OUT_WAIT watchdog limit (only used when MA_SCHED_TIMEOUT_EN is defined)
//   fifo_depth()     : result FIFO depth, two full tiles of output rows
package ma_sched_pkg;

  typedef enum logic [3:0] {
    IDLE,
    W_FETCH,
    W_BURST,
    X_FETCH,
    X_WAIT,
    X_BURST,
    OUT_WAIT,
    GUARD,
    DONE
  } sched_state_e;

  localparam int GUARD_CYCLES = 1;

  function automatic int timeout_cycles(input int mesh_length);
    return 4 * mesh_length + 8;
  endfunction

  function automatic int fifo_depth(input int mesh_length);
    return 2 * mesh_length;
  endfunction

endpackage

// File: rtl/ma_result_fifo.sv
// ma_result_fifo -- synchronous FIFO holding mesh result rows.
//   clk, rst_n : clock, asynchronous active-low reset (flushes pointers/count)
//   push, din  : write request and data; dropped when full unless a pop frees a slot
//   pop        : read request; ignored when empty
//   dout       : head entry, forced to 0 while empty
//   full, empty, free : occupancy status; free = DEPTH - count
// DEPTH must be a power of two so the pointers wrap naturally.
module ma_result_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    free
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign free    = CW'(DEPTH) - count;
  assign do_pop  = pop & ~empty;
  // A simultaneous pop frees the slot the push needs.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ma_tile_scheduler.sv
// ma_tile_scheduler -- sequences weight/image bursts into the systolic mesh and
// collects result rows into a FIFO.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   cmd_valid/ready, cmd_tiles : job command (number of image tiles)
//   w_valid/ready, w_data      : weight row stream from upstream
//   x_valid/ready, x_data      : image row stream from upstream
//   ma_weight(_load)           : registered weight burst to the mesh
//   ma_image(_load)            : registered image burst to the mesh
//   ma_out_valid_image/data    : mesh result rows
//   y_valid/ready, y_data      : result row stream out of the FIFO
//   done                       : one-cycle job-complete pulse
//   err                        : sticky error, cleared by the next accepted command
// Optional build macro MA_SCHED_TIMEOUT_EN adds an OUT_WAIT watchdog that aborts
// the job with err set when the mesh fails to return a tile in time.
module ma_tile_scheduler
  import ma_sched_pkg::*;
#(
  parameter int DATA_LENGTH = 8,
  parameter int MESH_LENGTH = 4,
  parameter int ACC_LENGTH  = 32,
  parameter int TILE_CNT_W  = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [TILE_CNT_W-1:0]             cmd_tiles,
  input  logic                              w_valid,
  output logic                              w_ready,
  input  logic [DATA_LENGTH*MESH_LENGTH-1:0] w_data,
  input  logic                              x_valid,
  output logic                              x_ready,
  input  logic [DATA_LENGTH*MESH_LENGTH-1:0] x_data,
  output logic [DATA_LENGTH*MESH_LENGTH-1:0] ma_weight,
  output logic [DATA_LENGTH*MESH_LENGTH-1:0] ma_image,
  output logic                              ma_weight_load,
  output logic                              ma_image_load,
  input  logic                              ma_out_valid_image,
  input  logic [ACC_LENGTH*MESH_LENGTH-1:0]  ma_out_data,
  output logic                              y_valid,
  input  logic                              y_ready,
  output logic [ACC_LENGTH*MESH_LENGTH-1:0]  y_data,
  output logic                              done,
  output logic                              err
);

  localparam int ROW_W      = DATA_LENGTH * MESH_LENGTH;
  localparam int OUT_W      = ACC_LENGTH * MESH_LENGTH;
  localparam int RC_W       = $clog2(MESH_LENGTH);
  localparam int FIFO_DEPTH = fifo_depth(MESH_LENGTH);
  localparam int FC_W       = $clog2(FIFO_DEPTH + 1);
  localparam int TMO        = timeout_cycles(MESH_LENGTH);
  localparam int TMR_W      = $clog2(TMO + 1);
  localparam logic [RC_W-1:0] LAST_ROW = RC_W'(MESH_LENGTH - 1);

  sched_state_e                      state, state_d;
  logic [RC_W-1:0]                   row_cnt, row_cnt_d, row_nxt;
  logic [TILE_CNT_W-1:0]             tiles_left, tiles_d;
  logic [TMR_W-1:0]                  tmr, tmr_d;
  logic                              err_d;
  logic                              wl_d, il_d;
  logic [ROW_W-1:0]                  mw_d, mi_d;

  // Single staging buffer shared by weight and image sets; only written in the
  // FETCH states, so a burst always reads a stable set.
  logic [MESH_LENGTH-1:0][ROW_W-1:0] stage;
  logic                              stage_we;
  logic [ROW_W-1:0]                  stage_din;

  logic                              fifo_push, fifo_full, fifo_empty;
  logic [FC_W-1:0]                   fifo_free;

  assign row_nxt   = row_cnt + RC_W'(1);
  assign cmd_ready = (state == IDLE);
  assign done      = (state == DONE);
  assign y_valid   = ~fifo_empty;
  assign stage_din = (state == W_FETCH) ? w_data : x_data;

  always_ff @(posedge clk) begin
    if (stage_we) stage[row_cnt] <= stage_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      row_cnt        <= '0;
      tiles_left     <= '0;
      tmr            <= '0;
      err            <= 1'b0;
      ma_weight_load <= 1'b0;
      ma_image_load  <= 1'b0;
      ma_weight      <= '0;
      ma_image       <= '0;
    end else begin
      state          <= state_d;
      row_cnt        <= row_cnt_d;
      tiles_left     <= tiles_d;
      tmr            <= tmr_d;
      err            <= err_d;
      ma_weight_load <= wl_d;
      ma_image_load  <= il_d;
      ma_weight      <= mw_d;
      ma_image       <= mi_d;
    end
  end

  // Mesh pins are registered: the cycle that completes a FETCH (or leaves
  // X_WAIT) already loads row 0, and each burst cycle preloads the next row,
  // so the strobe is high for exactly MESH_LENGTH back-to-back cycles.
  always_comb begin
    state_d   = state;
    row_cnt_d = row_cnt;
    tiles_d   = tiles_left;
    tmr_d     = tmr;
    err_d     = err;
    wl_d      = 1'b0;
    il_d      = 1'b0;
    mw_d      = '0;
    mi_d      = '0;
    w_ready   = 1'b0;
    x_ready   = 1'b0;
    stage_we  = 1'b0;
    fifo_push = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          tiles_d   = cmd_tiles;
          err_d     = 1'b0;
          row_cnt_d = '0;
          state_d   = W_FETCH;
        end
      end

      W_FETCH: begin
        w_ready = 1'b1;
        if (w_valid) begin
          stage_we = 1'b1;
          if (row_cnt == LAST_ROW) begin
            row_cnt_d = '0;
            wl_d      = 1'b1;
            mw_d      = stage[0];
            state_d   = W_BURST;
          end else begin
            row_cnt_d = row_nxt;
          end
        end
      end

      W_BURST: begin
        if (row_cnt == LAST_ROW) begin
          row_cnt_d = '0;
          state_d   = (tiles_left == '0) ? DONE : X_FETCH;
        end else begin
          row_cnt_d = row_nxt;
          wl_d      = 1'b1;
          mw_d      = stage[row_nxt];
        end
      end

      X_FETCH: begin
        x_ready = 1'b1;
        if (x_valid) begin
          stage_we = 1'b1;
          if (row_cnt == LAST_ROW) begin
            row_cnt_d = '0;
            state_d   = X_WAIT;
          end else begin
            row_cnt_d = row_nxt;
          end
        end
      end

      // Holding here until a whole tile of results fits is what makes FIFO
      // overflow unreachable in normal operation.
      X_WAIT: begin
        if (fifo_free >= FC_W'(MESH_LENGTH)) begin
          row_cnt_d = '0;
          il_d      = 1'b1;
          mi_d      = stage[0];
          state_d   = X_BURST;
        end
      end

      X_BURST: begin
        if (row_cnt == LAST_ROW) begin
          row_cnt_d = '0;
          tmr_d     = '0;
          state_d   = OUT_WAIT;
        end else begin
          row_cnt_d = row_nxt;
          il_d      = 1'b1;
          mi_d      = stage[row_nxt];
        end
      end

      OUT_WAIT: begin
        if (ma_out_valid_image) begin
          fifo_push = 1'b1;
          row_cnt_d = row_nxt;
        end
        if (ma_out_valid_image && row_cnt == LAST_ROW) begin
          row_cnt_d = '0;
          tiles_d   = tiles_left - 1'b1;
          tmr_d     = '0;
          state_d   = GUARD;
        end
`ifdef MA_SCHED_TIMEOUT_EN
        else if (tmr == TMR_W'(TMO - 1)) begin
          err_d     = 1'b1;
          row_cnt_d = '0;
          tmr_d     = '0;
          state_d   = DONE;
        end else begin
          tmr_d = tmr + TMR_W'(1);
        end
`endif
      end

      // Lets the mesh drop out of its output phase before the next image load.
      GUARD: begin
        if (tmr == TMR_W'(GUARD_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = (tiles_left != '0) ? X_FETCH : DONE;
        end else begin
          tmr_d = tmr + TMR_W'(1);
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    // Error sources are applied last so they win over the command-accept clear.
    if (ma_out_valid_image && state != OUT_WAIT) err_d = 1'b1;
    if (fifo_push && fifo_full && !(y_ready && !fifo_empty)) err_d = 1'b1;
  end

  ma_result_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (ma_out_data),
    .pop   (y_ready),
    .dout  (y_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .free  (fifo_free)
  );

endmodule

// File: tb/tb_ma_tile_scheduler.sv
// tb_ma_tile_scheduler -- directed bench for ma_tile_scheduler (MESH_LENGTH=4).
// A small mesh stub answers each image burst with MESH_LENGTH result rows
// derived from the captured image rows; expected results are derived from the
// image rows the bench itself sent.
module tb_ma_tile_scheduler;
  localparam int DL = 8, ML = 4, AL = 32, TW = 8;
  localparam int RW = DL * ML, OW = AL * ML;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          cmd_valid, cmd_ready;
  logic [TW-1:0] cmd_tiles;
  logic          w_valid, w_ready, x_valid, x_ready;
  logic [RW-1:0] w_data, x_data, ma_weight, ma_image;
  logic          ma_weight_load, ma_image_load;
  logic          mesh_vld, stray_vld, mesh_en;
  logic [OW-1:0] mesh_data, stray_data, y_data;
  logic          y_valid, y_ready, done, err;

  int checks = 0, errors = 0, cyc = 0, ndone = 0, overlap = 0, yv_cnt = 0;
  logic [OW-1:0] expq [$];

  always #5 clk = ~clk;

  ma_tile_scheduler #(.DATA_LENGTH(DL), .MESH_LENGTH(ML), .ACC_LENGTH(AL), .TILE_CNT_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_tiles(cmd_tiles),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .ma_weight(ma_weight), .ma_image(ma_image),
    .ma_weight_load(ma_weight_load), .ma_image_load(ma_image_load),
    .ma_out_valid_image(mesh_vld | stray_vld),
    .ma_out_data(stray_vld ? stray_data : mesh_data),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
    .done(done), .err(err)
  );

  function automatic logic [RW-1:0] wrow(input int r);
    return RW'(32'h10203040 + r * 32'h01010101);
  endfunction

  function automatic logic [RW-1:0] xrow(input int t, input int r);
    return RW'(32'hA0B0C0D0 + t * 32'h00100000 + r * 32'h01000101);
  endfunction

  function automatic logic [OW-1:0] mesh_row(input logic [RW-1:0] x);
    logic [OW-1:0] res;
    res = '0;
    for (int i = 0; i < ML; i++) res[i*AL +: AL] = AL'(x[i*DL +: DL]) * AL'(3) + AL'(i);
    return res;
  endfunction

  task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score any y handshake, count done pulses and strobe overlap,
  // then advance to 1 time unit past the next rising edge.
  task automatic step();
    if (y_valid) yv_cnt++;
    if (y_valid && y_ready) begin
      checks++;
      assert (expq.size() != 0) else begin
        errors++;
        $error("FAIL y_extra_row observed=%0h expected=no row", y_data);
      end
      if (expq.size() != 0) check("y_data", y_data, expq.pop_front());
    end
    if (done) ndone++;
    if (ma_weight_load && ma_image_load) overlap++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_cmd(input int tiles);
    check("cmd_ready_before_cmd", OW'(cmd_ready), OW'(1));
    cmd_valid = 1'b1;
    cmd_tiles = TW'(tiles);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic push_w(input bit gap);
    for (int r = 0; r < ML; r++) begin
      int n;
      bit hs;
      n = 0; hs = 1'b0;
      w_valid = 1'b1; w_data = wrow(r);
      while (!hs && n < 50) begin hs = w_ready; step(); n++; end
      check("w_accept", OW'(hs), OW'(1));
      w_valid = 1'b0;
      if (gap && r < ML - 1) step();
    end
  endtask

  task automatic push_x(input int t);
    for (int r = 0; r < ML; r++) begin
      int n;
      bit hs;
      n = 0; hs = 1'b0;
      x_valid = 1'b1; x_data = xrow(t, r);
      while (!hs && n < 50) begin hs = x_ready; step(); n++; end
      check("x_accept", OW'(hs), OW'(1));
      if (hs) expq.push_back(mesh_row(xrow(t, r)));
      x_valid = 1'b0;
    end
  endtask

  task automatic check_wburst();
    for (int k = 0; k < ML; k++) begin
      check("wload", OW'(ma_weight_load), OW'(1));
      check("wrow", OW'(ma_weight), OW'(wrow(k)));
      step();
    end
    check("wload_end", OW'(ma_weight_load), OW'(0));
  endtask

  task automatic wait_iburst(input int t);
    for (int i = 0; i < 40 && !ma_image_load; i++) step();
    check("iload_start", OW'(ma_image_load), OW'(1));
    for (int k = 0; k < ML; k++) begin
      check("iload", OW'(ma_image_load), OW'(1));
      check("irow", OW'(ma_image), OW'(xrow(t, k)));
      step();
    end
    check("iload_end", OW'(ma_image_load), OW'(0));
  endtask

  task automatic drain(input int n0, input int bound);
    for (int i = 0; i < bound && !(expq.size() == 0 && ndone > n0); i++) step();
    step(); step();
    check("rows_left", OW'(expq.size()), OW'(0));
    check("done_pulses", OW'(ndone - n0), OW'(1));
    check("back_idle", OW'(cmd_ready), OW'(1));
  endtask

  // Mesh stub: captures each image burst and replies with ML rows once it ends.
  initial begin : mesh_stub
    logic [RW-1:0] cap [ML];
    int cap_n, emit;
    cap_n = 0; emit = 0; mesh_vld = 1'b0; mesh_data = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        cap_n = 0; emit = 0; mesh_vld = 1'b0;
      end else begin
        if (ma_image_load && cap_n < ML) begin
          cap[cap_n] = ma_image; cap_n++;
        end else if (!ma_image_load && cap_n == ML) begin
          cap_n = 0;
          if (mesh_en) emit = ML;
        end
        if (emit > 0) begin
          mesh_vld = 1'b1; mesh_data = mesh_row(cap[ML-emit]); emit--;
        end else begin
          mesh_vld = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int n0, c0, yv0, il, nw;
    cmd_valid = 0; cmd_tiles = 0; w_valid = 0; w_data = 0; x_valid = 0; x_data = 0;
    y_ready = 1; stray_vld = 0; stray_data = 0; mesh_en = 1;
    step(); step();

    // Reset state
    check("rst_cmd_ready", OW'(cmd_ready), OW'(1));
    check("rst_wload", OW'(ma_weight_load), OW'(0));
    check("rst_iload", OW'(ma_image_load), OW'(0));
    check("rst_weight", OW'(ma_weight), OW'(0));
    check("rst_image", OW'(ma_image), OW'(0));
    check("rst_y_valid", OW'(y_valid), OW'(0));
    check("rst_y_data", y_data, OW'(0));
    check("rst_done", OW'(done), OW'(0));
    check("rst_err", OW'(err), OW'(0));
    check("rst_w_ready", OW'(w_ready), OW'(0));
    check("rst_x_ready", OW'(x_ready), OW'(0));
    rst_n = 1'b1;
    step();

    // One tile, continuous streams; first weight load ML+1 edges after the command
    n0 = ndone; c0 = cyc;
    send_cmd(1);
    push_w(1'b0);
    check("w_latency", OW'(cyc - c0), OW'(ML + 1));
    check_wburst();
    push_x(0);
    wait_iburst(0);
    drain(n0, 60);
    check("t1_err", OW'(err), OW'(0));

    // Weights only with w_valid toggling: burst stays contiguous, no results
    n0 = ndone; yv0 = yv_cnt;
    send_cmd(0);
    push_w(1'b1);
    check_wburst();
    for (int i = 0; i < 20 && ndone == n0; i++) step();
    step();
    check("t2_done", OW'(ndone - n0), OW'(1));
    check("t2_no_y", OW'(yv_cnt - yv0), OW'(0));
    check("t2_idle", OW'(cmd_ready), OW'(1));

    // Stray mesh row while idle: err set and sticky, row dropped
    stray_vld = 1'b1; stray_data = OW'(128'h1234);
    step();
    stray_vld = 1'b0;
    check("err_stray", OW'(err), OW'(1));
    step(); step();
    check("err_sticky", OW'(err), OW'(1));
    check("stray_dropped", OW'(y_valid), OW'(0));

    // Three tiles with y blocked: third tile held in X_WAIT until the FIFO drains
    y_ready = 1'b0; n0 = ndone;
    send_cmd(3);
    check("err_cleared", OW'(err), OW'(0));
    cmd_valid = 1'b1; cmd_tiles = 8'd7;
    push_w(1'b0);
    cmd_valid = 1'b0;
    check_wburst();
    push_x(0); wait_iburst(0);
    push_x(1); wait_iburst(1);
    push_x(2);
    il = 0;
    for (int i = 0; i < 20; i++) begin
      if (ma_image_load) il++;
      step();
    end
    check("t3_hold", OW'(il), OW'(0));
    check("t3_fifo_full", OW'(y_valid), OW'(1));
    check("t3_x_ready", OW'(x_ready), OW'(0));
    check("t3_busy", OW'(cmd_ready), OW'(0));
    y_ready = 1'b1;
    wait_iburst(2);
    drain(n0, 80);
    check("t3_err", OW'(err), OW'(0));

    // Mesh never answers
    n0 = ndone; mesh_en = 1'b0;
    send_cmd(1);
    push_w(1'b0);
    check_wburst();
    push_x(3);
    wait_iburst(3);
    expq.delete();
`ifdef MA_SCHED_TIMEOUT_EN
    nw = 0;
    while (!err && nw < 60) begin step(); nw++; end
    check("tmo_cycles", OW'(nw), OW'(4 * ML + 8));
    check("tmo_err", OW'(err), OW'(1));
    check("tmo_done", OW'(done), OW'(1));
    step();
    check("tmo_idle", OW'(cmd_ready), OW'(1));
    check("tmo_done_pulses", OW'(ndone - n0), OW'(1));
`else
    nw = 0;
    repeat (40) begin step(); nw++; end
    check("wait_err", OW'(err), OW'(0));
    check("wait_busy", OW'(cmd_ready), OW'(0));
    check("wait_no_done", OW'(ndone - n0), OW'(0));
    for (int r = 0; r < ML; r++) begin
      stray_vld = 1'b1; stray_data = mesh_row(xrow(3, r));
      expq.push_back(mesh_row(xrow(3, r)));
      step();
    end
    stray_vld = 1'b0;
    drain(n0, 40);
    check("late_err", OW'(err), OW'(0));
`endif
    mesh_en = 1'b1;

    // Reset asserted in the middle of an image burst, FIFO holding results
    y_ready = 1'b0;
    send_cmd(2);
    push_w(1'b0);
    check_wburst();
    push_x(4); wait_iburst(4);
    push_x(5);
    for (int i = 0; i < 40 && !ma_image_load; i++) step();
    step();
    check("pre_rst_iload", OW'(ma_image_load), OW'(1));
    check("pre_rst_y_valid", OW'(y_valid), OW'(1));
    rst_n = 1'b0;
    #1;
    check("arst_iload", OW'(ma_image_load), OW'(0));
    check("arst_image", OW'(ma_image), OW'(0));
    check("arst_wload", OW'(ma_weight_load), OW'(0));
    check("arst_cmd_ready", OW'(cmd_ready), OW'(1));
    check("arst_y_valid", OW'(y_valid), OW'(0));
    check("arst_y_data", y_data, OW'(0));
    check("arst_done", OW'(done), OW'(0));
    expq.delete();
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_idle", OW'(cmd_ready), OW'(1));
    check("post_rst_y_valid", OW'(y_valid), OW'(0));

    check("no_strobe_overlap", OW'(overlap), OW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
